// File: rtl/gmii_pkg.sv
// Shared types and defaults for the GMII transmit arbiter.
// States, frame limits and GMII framing constants.
package gmii_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_IFG  = 2'd2
  } state_t;

  localparam int IFG_BYTES_DEF       = 12;
  localparam int MAX_FRAME_BYTES_DEF = 1526;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         PREAMBLE_LEN  = 7;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v,
    input logic        en
  );
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

endpackage

// File: rtl/gmii_tx_arbiter_if.sv
// Two-source frame request / byte stream bundle.
// master = the frame sources, slave = the arbiter.
interface gmii_tx_arbiter_if;
  logic       req0;
  logic       gnt0;
  logic [7:0] d0;
  logic       v0;
  logic       last0;
  logic       req1;
  logic       gnt1;
  logic [7:0] d1;
  logic       v1;
  logic       last1;

  modport master (
    output req0, d0, v0, last0,
    output req1, d1, v1, last1,
    input  gnt0, gnt1
  );

  modport slave (
    input  req0, d0, v0, last0,
    input  req1, d1, v1, last1,
    output gnt0, gnt1
  );
endinterface

// File: rtl/gmii_tx_arbiter_rr_arb2.sv
// Two-way round-robin pick; last=1 means source 1 was
// served most recently, so a tie goes to source 0.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = req;
    unique case (req)
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = req;
    endcase
  end
endmodule

// File: rtl/gmii_tx_arbiter.sv
// Two-source GMII transmit arbiter with underrun/oversize abort.
// Optional stats counters under GMII_TX_ARB_STATS_EN.
module gmii_tx_arbiter
  import gmii_pkg::*;
#(
  parameter int IFG_BYTES       = IFG_BYTES_DEF,
  parameter int MAX_FRAME_BYTES = MAX_FRAME_BYTES_DEF
) (
  input  logic               GMII_GTXCLK,
  input  logic               rst_n,
  gmii_tx_arbiter_if.slave   src,
  output logic [7:0]         GMII_TXD,
  output logic               GMII_TXEN,
  output logic               GMII_TXER,
  output logic               busy,
  output logic               abort_p
`ifdef GMII_TX_ARB_STATS_EN
  ,
  output logic [15:0]        frm_cnt0,
  output logic [15:0]        frm_cnt1,
  output logic [15:0]        err_cnt
`endif
);

  localparam int IW =
    (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;
  localparam logic [IW-1:0] IFG_LAST =
    IW'(IFG_BYTES - 1);
  localparam logic [10:0] MAX_CNT =
    11'(MAX_FRAME_BYTES);

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          ptr_q, ptr_d;
  logic [10:0]   cnt_q, cnt_d;
  logic [IW-1:0] ifg_q, ifg_d;
  logic [7:0]    txd_q, txd_d;
  logic          txen_q, txen_d;
  logic          txer_q, txer_d;
  logic          abort_q, abort_d;

  logic [1:0]    win;
  logic          sel;
  logic [7:0]    s_d;
  logic          s_v, s_last, s_req;
  logic          done_ok, done_err;

  rr_arb2 u_rr (
    .req  ({src.req1, src.req0}),
    .last (ptr_q),
    .gnt  (win)
  );

  assign sel    = gnt_q[1];
  assign s_d    = sel ? src.d1    : src.d0;
  assign s_v    = sel ? src.v1    : src.v0;
  assign s_last = sel ? src.last1 : src.last0;
  assign s_req  = sel ? src.req1  : src.req0;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ifg_d    = ifg_q;
    txd_d    = 8'h00;
    txen_d   = 1'b0;
    txer_d   = 1'b0;
    abort_d  = 1'b0;
    done_ok  = 1'b0;
    done_err = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|win) begin
          gnt_d   = win;
          cnt_d   = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        // byte MAX+1 without last is an oversize frame
        if (s_v && !(cnt_q == MAX_CNT && !s_last)) begin
          txd_d   = s_d;
          txen_d  = 1'b1;
          cnt_d   = cnt_q + 11'd1;
          done_ok = s_last;
        end else if (s_v || cnt_q != '0) begin
          txen_d   = 1'b1;
          txer_d   = 1'b1;
          abort_d  = 1'b1;
          done_err = 1'b1;
        end else if (!s_req) begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end
        if (done_ok || done_err) begin
          gnt_d   = '0;
          ptr_d   = sel;
          ifg_d   = '0;
          state_d = S_IFG;
        end
      end
      S_IFG: begin
        if (ifg_q == IFG_LAST)
          state_d = S_IDLE;
        else
          ifg_d = ifg_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge GMII_GTXCLK) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= 1'b1;
      cnt_q   <= '0;
      ifg_q   <= '0;
      txd_q   <= 8'h00;
      txen_q  <= 1'b0;
      txer_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ifg_q   <= ifg_d;
      txd_q   <= txd_d;
      txen_q  <= txen_d;
      txer_q  <= txer_d;
      abort_q <= abort_d;
    end
  end

  assign src.gnt0  = gnt_q[0];
  assign src.gnt1  = gnt_q[1];
  assign GMII_TXD  = txd_q;
  assign GMII_TXEN = txen_q;
  assign GMII_TXER = txer_q;
  assign abort_p   = abort_q;
  assign busy      = (state_q != S_IDLE);

`ifdef GMII_TX_ARB_STATS_EN
  logic [15:0] frm0_q, frm0_d;
  logic [15:0] frm1_q, frm1_d;
  logic [15:0] err_q, err_d;

  always_comb begin
    frm0_d = sat_inc16(frm0_q, done_ok && !sel);
    frm1_d = sat_inc16(frm1_q, done_ok && sel);
    err_d  = sat_inc16(err_q, done_err);
  end

  always_ff @(posedge GMII_GTXCLK) begin
    if (!rst_n) begin
      frm0_q <= '0;
      frm1_q <= '0;
      err_q  <= '0;
    end else begin
      frm0_q <= frm0_d;
      frm1_q <= frm1_d;
      err_q  <= err_d;
    end
  end

  assign frm_cnt0 = frm0_q;
  assign frm_cnt1 = frm1_q;
  assign err_cnt  = err_q;
`endif

endmodule
